// File: rtl/pipeline_pkg.sv
// Shared execute-stage definitions: mult/div op codes
// and the iterative multiply/divide FSM state type.
package pipeline_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring-subtract divide on unsigned magnitudes.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc[WIDTH-1:0]}
         + {1'b0, (q[0] ? b : '0)};
    sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff = sh - {1'b0, b};
    acc_n = '0;
    q_n   = '0;
    if (is_div) begin
      // diff[WIDTH] is the borrow: set means restore
      if (!diff[WIDTH]) begin
        acc_n = diff;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = sh;
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = {1'b0, sum[WIDTH:1]};
      q_n   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO, mthi/mtlo
// write ports and squash support for the execute stage.
module muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign busy = (state != IDLE);

  always_comb begin
    a_neg = op[0] & src_a[WIDTH-1];
    b_neg = op[0] & src_b[WIDTH-1];
    a_abs = a_neg ? -src_a : src_a;
    b_abs = b_neg ? -src_b : src_b;
  end

  always_comb begin
    prod   = {acc[WIDTH-1:0], q};
    prod_f = neg_q ? -prod : prod;
    quot   = neg_q ? -q : q;
    rem    = neg_r ? -acc[WIDTH-1:0]
                   : acc[WIDTH-1:0];
    if (div0) quot = '1;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc    (acc),
    .q      (q),
    .b      (b_mag),
    .acc_n  (acc_n),
    .q_n    (q_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      q           <= '0;
      b_mag       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div0        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start && !flush) begin
            state  <= RUN;
            count  <= '0;
            acc    <= '0;
            q      <= a_abs;
            b_mag  <= b_abs;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= op[1] & (src_b == '0);
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= acc_n;
            q     <= q_n;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1))
              state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi          <= rem;
              lo          <= quot;
              div_by_zero <= div0;
            end else begin
              hi <= prod_f[2*WIDTH-1:WIDTH];
              lo <= prod_f[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboarded results,
// latency, HI/LO write rules, flush and async reset.
module tb_muldiv_unit;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush, wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int n_chk  = 0;
  int n_fail = 0;
  logic [64:0] sb[$];
  logic [15:0] sb8[$];
  logic [31:0] last_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .op(op), .src_a(src_a[7:0]), .src_b(src_b[7:0]),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data[7:0]), .busy(busy8),
    .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // {dbz, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model(
      input logic [1:0] o,
      input logic [31:0] a, b);
    logic signed [63:0] sa, sb_, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    case (o)
      MD_MULTU: p = {32'h0, a} * {32'h0, b};
      MD_MULT:  p = sa * sb_;
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == MD_DIVU) begin
          p = {{32'h0, a} % {32'h0, b}}
              << 32 | ({32'h0, a} / {32'h0, b});
        end else begin
          sq = sa / sb_;
          sr = sa % sb_;
          p = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return {1'b0, p};
  endfunction

  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [31:0] a, b);
    int lat, bcyc;
    logic [64:0] e;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    sb.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    bcyc = busy ? 1 : 0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
      if (done) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cyc"}, 64'(bcyc), 64'd33);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      check({tag, "_dbz"}, 64'(dbz), 64'(e[64]));
      last_lo = e[31:0];
    end
  endtask

  initial begin
    int lat, nd, nb;
    logic [15:0] e8;
    reset = 1'b0; start = 0; start8 = 0;
    op = 0; src_a = 0; src_b = 0; flush = 0;
    wr_hi = 0; wr_lo = 0; wr_data = 0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b1;

    do_op("multu_max", MD_MULTU,
          32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
    do_op("mult_m3x5", MD_MULT, -32'sd3, 32'd5);
    check("mult_lo_const", 64'(lo), 64'hFFFF_FFF1);
    do_op("div_m7_2", MD_DIV, -32'sd7, 32'd2);
    do_op("div_min_m1", MD_DIV,
          32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_pos_neg", MD_DIV, 32'd100, -32'sd7);
    do_op("divu_5_0", MD_DIVU, 32'd5, 32'd0);
    @(posedge clk); #1;
    check("dbz_drop", 64'(dbz), 64'd0);
    check("done_drop", 64'(done), 64'd0);
    do_op("div_neg_0", MD_DIV, -32'sd9, 32'd0);
    do_op("divu_big", MD_DIVU,
          32'hDEAD_BEEF, 32'h0000_1234);
    do_op("mult_rand", MD_MULT, $urandom, $urandom);
    do_op("div_rand", MD_DIV, $urandom, $urandom);

    // WIDTH=8 instance
    @(negedge clk);
    start8 = 1'b1; op = MD_MULT;
    src_a = 32'hFD; src_b = 32'h05;
    sb8.push_back(16'hFFF1);
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    check("w8_latency", 64'(lat), 64'd9);
    if (done8 && sb8.size() > 0) begin
      e8 = sb8.pop_front();
      check("w8_hi", 64'(hi8), 64'(e8[15:8]));
      check("w8_lo", 64'(lo8), 64'(e8[7:0]));
    end

    // preload hi, then ignored writes/start, then flush
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'hAAAA_AAAA;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi", 64'(hi), 64'hAAAA_AAAA);
    start = 1'b1; op = MD_MULTU;
    src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_lo = 1'b1; wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    start = 1'b1; op = MD_DIVU;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi), 64'hAAAA_AAAA);
    check("flush_lo", 64'(lo), 64'(last_lo));
    nd = 0; nb = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (busy) nb++;
    end
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_no_busy", 64'(nb), 64'd0);

    // async reset mid-run
    @(negedge clk);
    start = 1'b1; op = MD_MULTU;
    src_a = 32'h1234; src_b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("run20_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("areset_hi", 64'(hi), 64'd0);
    check("areset_lo", 64'(lo), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_done", 64'(done), 64'd0);
    check("areset_dbz", 64'(dbz), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    nd = 0; nb = 0;
    repeat (40) begin
      if (busy) nb++;
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("sflush_busy", 64'(nb), 64'd0);
    check("sflush_done", 64'(nd), 64'd0);

    do_op("post_reset", MD_DIVU, 32'd100, 32'd7);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS datapath. It generalises the fixed 32-bit multiplier with these additions: a configurable `WIDTH`, signed and unsigned divide, architectural HI/LO registers with `mthi`/`mtlo` write ports, and a flush input. The flush cancels an in-flight operation when the execute stage is squashed. `busy` feeds the hazard unit so that it can stall `mfhi`/`mflo` and any new mult/div until the result has been committed.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and HI/LO width; legal range is `WIDTH` ≥ 4.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `op`  in  2: `op[1]` 0 = multiply, 1 = divide; `op[0]` 0 = unsigned, 1 = signed.
- `src_a`  in  `WIDTH`: multiplicand / dividend.
- `src_b`  in  `WIDTH`: multiplier / divisor.
- `flush`  in  1: cancels the current or requested operation.
- `wr_hi`, `wr_lo`  in  1 each: mthi/mtlo write enables.
- `wr_data`  in  `WIDTH`: mthi/mtlo data.
- `busy`  out  1: high when the state is not IDLE.
- `done`  out  1: one-cycle pulse when HI/LO are committed.
- `div_by_zero`  out  1: valid only while `done` is high.
- `hi`, `lo`  out  `WIDTH` each: architectural HI/LO registers.

## Operation
FSM states: IDLE, RUN, FIXUP.

IDLE:
- `start=1` and `flush=0`: latch operand magnitudes, result signs and `op`; clear `count`; go to RUN.
- `flush` has priority over `start` in the same cycle, and that `start` is dropped.

RUN:
- Each edge performs one radix-2 step:
  - multiply: shift-add;
  - divide: restoring subtract.
- `count` increments each edge. After `WIDTH` steps the FSM goes to FIXUP.

FIXUP:
- Apply sign correction, write HI/LO, register `done=1`, go to IDLE.

`flush=1` in RUN or FIXUP:
- Next state is IDLE.
- HI/LO are not written and `done` stays 0.

Multiply results:
- `{hi,lo}` is the full 2·`WIDTH`-bit product.
- For signed multiply, the product is negated when the operand signs differ.

Divide results:
- `lo` is the quotient and `hi` is the remainder.
- Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed MIN / −1 gives `lo`=MIN, `hi`=0 (natural result of magnitude wrap; no flag).
- Divide by zero (`src_b`=0): `lo`=all ones, `hi`=`src_a` as latched, `div_by_zero`=1 during the `done` cycle. It still takes the full latency.

HI/LO writes (`wr_hi` / `wr_lo`):
- Honoured only when `busy=0`; ignored while `busy=1`.
- A write in the same IDLE cycle as `start` is applied, and is later overwritten by the result.

`start` while `busy=1` is ignored.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0; state IDLE; `count`=0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous). Pending results are lost.
- Start accepted at edge k:
  - `busy` rises after edge k.
  - RUN covers edges k+1 … k+`WIDTH`.
  - FIXUP edge is k+`WIDTH`+1: HI/LO update, `done` rises and `busy` falls after this same edge.
  - Latency is `WIDTH`+1 edges (33 for `WIDTH`=32).
- `done` is high for exactly one cycle.
- A new `start` is accepted in the `done` cycle, since the FSM is in IDLE.
- `count` width is clog2(`WIDTH`+1). Internal remainder/accumulator is `WIDTH`+1 bits to hold the subtract borrow.
- `hi`/`lo` are driven directly from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `pipeline_pkg` holds:
  - op encodings: `MD_MULTU`=2'b00, `MD_MULT`=2'b01, `MD_DIVU`=2'b10, `MD_DIV`=2'b11;
  - the `md_state_t` enum (IDLE, RUN, FIXUP).
- One combinational sub-module, `muldiv_step`: a single radix-2 iteration selecting shift-add or restoring subtract. It is instantiated once and is parametrised by `WIDTH`.
- Sign/magnitude conversion, the FSM and HI/LO stay in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` asserts exactly 33 edges after the start edge; `busy` is high for 33 cycles.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Also repeat with `WIDTH`=8: −3 × 5 → `hi`=0xFF, `lo`=0xF1, latency 9.
- Signed divide cases:
  - DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 only during the `done` cycle.
- Preload `hi`=0xAAAA_AAAA via `wr_hi`, start MULTU, then:
  - assert `wr_lo` at RUN cycle 4 → ignored;
  - `start` at cycle 5 → ignored;
  - `flush` at cycle 10 → `busy`=0 next cycle, no `done`, `hi` still 0xAAAA_AAAA.
- Pull `reset` low at RUN cycle 20 → all outputs 0 without a clock edge. After release, `start`+`flush` together → no operation, `busy` stays 0.
